// File: rtl/fetch_unit_pkg.sv
// Shared core definitions: data width, the canonical NOP encoding and the fetch FSM state type.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  // Fetch addresses are always word aligned; the low two bits of any redirect are discarded.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage (master) and memory (slave).
interface fetch_unit_if;
  import core_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_if_de_reg.sv
// IF/DE pipeline register: flush beats stall beats load; with nothing loaded it inserts a bubble.
module if_de_reg
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid_out,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // A bubble keeps the last PC so only valid/instr change.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (stall) begin
      valid_d = valid_q;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_out    = valid_q;
  assign instr_out    = instr_q;
  assign pc_out       = pc_q;
  assign pc_plus4_out = pc_q + XLEN'(4);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with one outstanding imem request, stall buffer and redirect handling.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_stall,
  input  logic            de_stall,
  input  logic            de_flush,
  input  logic            ex_pc_src,
  input  logic [XLEN-1:0] ex_pc_target,
  fetch_unit_if.master    imem,
  output logic            de_valid,
  output logic [XLEN-1:0] de_instr,
  output logic [XLEN-1:0] de_pc,
  output logic [XLEN-1:0] de_pc_plus4,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pending_q, pending_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            req_valid_q, req_valid_d;

  logic            adv;
  logic            redir;
  logic            rsp;
  logic            handshake;
  logic [XLEN-1:0] target;
  logic            deliver;
  logic [XLEN-1:0] deliver_instr;

  assign adv       = !if_stall && !de_stall;
  assign redir     = ex_pc_src;
  assign rsp       = imem.imem_rsp_valid;
  assign handshake = (state_q == REQ) && imem.imem_req_ready;
  assign target    = align_word(ex_pc_target);

  // A request accepted after a redirect is already stale, so its response is routed through DROP.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pending_d     = pending_q;
    pending_pc_d  = pending_pc_q;
    buf_d         = buf_q;
    deliver       = 1'b0;
    deliver_instr = buf_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (handshake) begin
          if (redir) begin
            pending_d    = 1'b1;
            pending_pc_d = target;
            state_d      = DROP;
          end else if (pending_q) begin
            state_d = DROP;
          end else begin
            state_d = WAIT;
          end
        end else if (redir) begin
          pending_d    = 1'b1;
          pending_pc_d = target;
        end
      end
      WAIT: begin
        if (rsp && redir) begin
          pc_d    = target;
          state_d = REQ;
        end else if (redir) begin
          pc_d         = target;
          pending_d    = 1'b1;
          pending_pc_d = target;
          state_d      = DROP;
        end else if (rsp && adv) begin
          deliver       = 1'b1;
          deliver_instr = imem.imem_rdata;
          pc_d          = pc_q + XLEN'(4);
          state_d       = REQ;
        end else if (rsp) begin
          buf_d   = imem.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_d    = target;
          state_d = REQ;
        end else if (adv) begin
          deliver = 1'b1;
          pc_d    = pc_q + XLEN'(4);
          state_d = REQ;
        end
      end
      DROP: begin
        if (rsp) begin
          pc_d      = redir ? target : pending_pc_q;
          pending_d = 1'b0;
          state_d   = REQ;
        end else if (redir) begin
          pc_d         = target;
          pending_pc_d = target;
        end
      end
      default: state_d = IDLE;
    endcase
    req_valid_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= RESET_PC;
      buf_q        <= NOP_INSTR;
      req_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      buf_q        <= buf_d;
      req_valid_q  <= req_valid_d;
    end
  end

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_addr      = pc_q;

  if_de_reg u_if_de_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (de_flush),
    .stall        (de_stall),
    .load         (deliver),
    .instr_in     (deliver_instr),
    .pc_in        (pc_q),
    .valid_out    (de_valid),
    .instr_out    (de_instr),
    .pc_out       (de_pc),
    .pc_plus4_out (de_pc_plus4)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;
  logic        drop_evt;

  // Anything thrown away counts as dropped: a stale response or a buffered word killed by a redirect.
  assign drop_evt = ((state_q == WAIT) && rsp && redir) ||
                    ((state_q == HOLD) && redir) ||
                    ((state_q == DROP) && rsp);

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_dropped_d = perf_dropped_q;
    if (deliver && !de_flush) perf_fetched_d = perf_fetched_q + 32'd1;
    if (drop_evt)             perf_dropped_d = perf_dropped_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`else
  assign perf_fetched = '0;
  assign perf_dropped = '0;
`endif

endmodule
